// File: rtl/aes_round_engine_if.sv
// rtl/aes_round_engine_if.sv - block-in, round-key fetch and ciphertext-out signals of the AES round engine
interface aes_round_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES encryption datapath, one full round per clock
module aes_round_engine #(
  parameter int NR = 10
) (
  input logic              clk,
  input logic              reset,
  aes_round_engine_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NR);

  // S-box packed with entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state, state_nx;
  logic [127:0]   st, st_nx;
  logic [3:0]     round, round_nx;
  logic [0:15][7:0] sb, sr, mc;

  // byte 4c+r sits at row r, column c
  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(st[127-8*i -: 8]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
      assign mc[4*c+r] = xt(sr[4*c+r]) ^ xt(sr[4*c+(r+1)%4]) ^ sr[4*c+(r+1)%4]
                       ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      st    <= '0;
      round <= '0;
    end else begin
      state <= state_nx;
      st    <= st_nx;
      round <= round_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    st_nx         = st;
    round_nx      = round;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.rk_idx    = 4'd0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          st_nx    = bus.in_data ^ bus.rk;
          round_nx = 4'd1;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        bus.busy   = 1'b1;
        bus.rk_idx = round;
        if (round == LAST) begin
          st_nx    = sr ^ bus.rk;
          state_nx = DONE;
        end else begin
          st_nx    = mc ^ bus.rk;
          round_nx = round + 4'd1;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
          round_nx = 4'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.out_data = st;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - self-checking bench for aes_round_engine at NR=10, 12 and 14
module tb_aes_round_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  aes_round_engine_if bus0();
  aes_round_engine_if bus1();
  aes_round_engine_if bus2();

  aes_round_engine #(.NR(10)) u_dut10 (.clk(clk), .reset(reset), .bus(bus0.slave));
  aes_round_engine #(.NR(12)) u_dut12 (.clk(clk), .reset(reset), .bus(bus1.slave));
  aes_round_engine #(.NR(14)) u_dut14 (.clk(clk), .reset(reset), .bus(bus2.slave));

  logic [2:0]   in_valid_a = '0;
  logic [2:0]   out_ready_a = '0;
  logic [127:0] in_data_a [3];
  logic [127:0] rks [3][16];
  logic [2:0]   in_ready_w, out_valid_w, busy_w;
  logic [3:0]   rk_idx_w [3];
  logic [127:0] out_data_w [3];
  logic [7:0]   sbox_t [256];

  assign bus0.in_valid = in_valid_a[0];
  assign bus1.in_valid = in_valid_a[1];
  assign bus2.in_valid = in_valid_a[2];
  assign bus0.out_ready = out_ready_a[0];
  assign bus1.out_ready = out_ready_a[1];
  assign bus2.out_ready = out_ready_a[2];
  assign bus0.in_data = in_data_a[0];
  assign bus1.in_data = in_data_a[1];
  assign bus2.in_data = in_data_a[2];
  assign bus0.rk = rks[0][bus0.rk_idx];
  assign bus1.rk = rks[1][bus1.rk_idx];
  assign bus2.rk = rks[2][bus2.rk_idx];
  assign in_ready_w  = {bus2.in_ready, bus1.in_ready, bus0.in_ready};
  assign out_valid_w = {bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign busy_w      = {bus2.busy, bus1.busy, bus0.busy};
  assign rk_idx_w[0] = bus0.rk_idx;
  assign rk_idx_w[1] = bus1.rk_idx;
  assign rk_idx_w[2] = bus2.rk_idx;
  assign out_data_w[0] = bus0.out_data;
  assign out_data_w[1] = bus1.out_data;
  assign out_data_w[2] = bus2.out_data;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from the field inverse and affine map
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic fill_keys(input int d, input logic [255:0] key, input int nk);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [255:0] k;
    logic [7:0]   rcon;
    int nr;
    nr = nk + 6; rcon = 8'h01; k = key;
    for (int i = 0; i < nk; i++) begin
      w[i] = k[255:224];
      k = k << 32;
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rks[d][r] = '0;
    for (int r = 0; r <= nr; r++) rks[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input int d, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] x, y;
    int nr;
    nr = 10 + 2 * d;
    x = pt ^ rks[d][0];
    for (int i = 0; i < 16; i++) begin s[i] = x[127:120]; x = x << 8; end
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd < nr) ? (gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                  ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4]) : t[4*c+r];
      y = rks[d][rd];
      for (int i = 0; i < 16; i++) begin s[i] = s[i] ^ y[127:120]; y = y << 8; end
    end
    x = '0;
    for (int i = 0; i < 16; i++) x = {x[119:0], s[i]};
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a falling edge; returns in the first DONE cycle with out_ready low
  task automatic run_to_done(input int d, input logic [127:0] pt, input logic [127:0] exp,
                             input bit chk_idx, input int pulse_at);
    int nr;
    nr = 10 + 2 * d;
    in_valid_a[d] = 1'b1; in_data_a[d] = pt; out_ready_a[d] = 1'b0;
    #1;
    checks++; if (in_ready_w[d] !== 1'b1) begin errors++; $display("FAIL accept_ready d=%0d: got %b want 1", d, in_ready_w[d]); end
    if (chk_idx) begin
      checks++; if (rk_idx_w[d] !== 4'd0) begin errors++; $display("FAIL rk_idx_idle d=%0d: got %0d want 0", d, rk_idx_w[d]); end
    end
    @(negedge clk); in_valid_a[d] = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      if (chk_idx) begin
        checks++; if (rk_idx_w[d] !== 4'(k)) begin errors++; $display("FAIL rk_idx_round d=%0d: got %0d want %0d", d, rk_idx_w[d], k); end
      end
      checks++; if (out_valid_w[d] !== 1'b0 || busy_w[d] !== 1'b1 || in_ready_w[d] !== 1'b0) begin
        errors++; $display("FAIL round_flags d=%0d k=%0d: got v=%b b=%b r=%b want v=0 b=1 r=0", d, k, out_valid_w[d], busy_w[d], in_ready_w[d]);
      end
      if (k == pulse_at) begin in_valid_a[d] = 1'b1; in_data_a[d] = '1; end
      @(negedge clk); in_valid_a[d] = 1'b0;
    end
    checks++; if (out_valid_w[d] !== 1'b1) begin errors++; $display("FAIL out_valid_latency d=%0d: got %b want 1", d, out_valid_w[d]); end
    checks++; if (out_data_w[d] !== exp) begin errors++; $display("FAIL out_data d=%0d: got %h want %h", d, out_data_w[d], exp); end
    if (chk_idx) begin
      checks++; if (rk_idx_w[d] !== 4'd0) begin errors++; $display("FAIL rk_idx_done d=%0d: got %0d want 0", d, rk_idx_w[d]); end
    end
  endtask

  task automatic finish_block(input int d);
    out_ready_a[d] = 1'b1;
    @(negedge clk); out_ready_a[d] = 1'b0;
    checks++; if (in_ready_w[d] !== 1'b1 || out_valid_w[d] !== 1'b0 || busy_w[d] !== 1'b0) begin
      errors++; $display("FAIL after_handshake d=%0d: got r=%b v=%b b=%b want r=1 v=0 b=0", d, in_ready_w[d], out_valid_w[d], busy_w[d]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++; if (in_ready_w[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready d=%0d: got %b want 1", d, in_ready_w[d]); end
      checks++; if (out_valid_w[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid d=%0d: got %b want 0", d, out_valid_w[d]); end
      checks++; if (busy_w[d] !== 1'b0) begin errors++; $display("FAIL reset_busy d=%0d: got %b want 0", d, busy_w[d]); end
      checks++; if (rk_idx_w[d] !== 4'd0) begin errors++; $display("FAIL reset_rk_idx d=%0d: got %0d want 0", d, rk_idx_w[d]); end
      checks++; if (out_data_w[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data d=%0d: got %h want 0", d, out_data_w[d]); end
    end
    reset = 1'b0;
  endtask

  task automatic test_fips_b();
    fill_keys(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    @(negedge clk);
    run_to_done(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 0);
    finish_block(0);
  endtask

  task automatic test_fips_c();
    logic [127:0] expc [3];
    logic [255:0] key;
    logic [127:0] m;
    expc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    expc[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    expc[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int d = 0; d < 3; d++) begin
      key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
          & ({256{1'b1}} << (256 - 32 * (4 + 2 * d)));
      fill_keys(d, key, 4 + 2 * d);
      m = model_enc(d, 128'h00112233445566778899aabbccddeeff);
      checks++; if (m !== expc[d]) begin errors++; $display("FAIL model_fips_c d=%0d: got %h want %h", d, m, expc[d]); end
      @(negedge clk);
      run_to_done(d, 128'h00112233445566778899aabbccddeeff, expc[d], 1'b1, 0);
      finish_block(d);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] pt, held;
    fill_keys(0, {rand128(), 128'h0}, 4);
    pt = rand128();
    @(negedge clk);
    run_to_done(0, pt, model_enc(0, pt), 1'b0, 0);
    held = out_data_w[0];
    repeat (7) begin
      @(negedge clk);
      checks++; if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0 || out_data_w[0] !== held) begin
        errors++; $display("FAIL backpressure: got v=%b r=%b data=%h want v=1 r=0 data=%h", out_valid_w[0], in_ready_w[0], out_data_w[0], held);
      end
    end
    finish_block(0);
  endtask

  task automatic test_busy_ignore();
    logic [127:0] pt;
    fill_keys(1, {rand128(), $urandom, $urandom, 64'h0}, 6);
    pt = rand128();
    @(negedge clk);
    run_to_done(1, pt, model_enc(1, pt), 1'b0, 4);
    finish_block(1);
    repeat (14) begin
      @(negedge clk);
      checks++; if (out_valid_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin
        errors++; $display("FAIL busy_ignore_extra: got v=%b b=%b want v=0 b=0", out_valid_w[1], busy_w[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    fill_keys(2, {rand128(), rand128()}, 8);
    @(negedge clk);
    in_valid_a[2] = 1'b1; in_data_a[2] = rand128();
    @(negedge clk); in_valid_a[2] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rk_idx_w[2] !== 4'd5) begin errors++; $display("FAIL reset_mid_round: got %0d want 5", rk_idx_w[2]); end
    reset = 1'b1;
    #1;
    checks++; if (out_valid_w[2] !== 1'b0 || in_ready_w[2] !== 1'b1 || busy_w[2] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got v=%b r=%b b=%b want v=0 r=1 b=0", out_valid_w[2], in_ready_w[2], busy_w[2]);
    end
    checks++; if (rk_idx_w[2] !== 4'd0 || out_data_w[2] !== 128'h0) begin
      errors++; $display("FAIL reset_mid_state: got idx=%0d data=%h want idx=0 data=0", rk_idx_w[2], out_data_w[2]);
    end
    @(negedge clk); reset = 1'b0;
    pt = rand128();
    run_to_done(2, pt, model_enc(2, pt), 1'b1, 0);
    finish_block(2);
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [4];
    logic [127:0] exp [4];
    int acc [4];
    int outc [4];
    int na, no, cyc;
    na = 0; no = 0; cyc = 0;
    fill_keys(0, {rand128(), 128'h0}, 4);
    for (int i = 0; i < 4; i++) begin blk[i] = rand128(); exp[i] = model_enc(0, blk[i]); end
    @(negedge clk);
    out_ready_a[0] = 1'b1;
    while (no < 4 && cyc < 100) begin
      if (out_valid_w[0] === 1'b1) begin
        outc[no] = cyc;
        checks++; if (out_data_w[0] !== exp[no]) begin errors++; $display("FAIL b2b_data blk=%0d: got %h want %h", no, out_data_w[0], exp[no]); end
        checks++; if (outc[no] - acc[no] != 11) begin errors++; $display("FAIL b2b_latency blk=%0d: got %0d want 11", no, outc[no] - acc[no]); end
        if (no > 0) begin
          checks++; if (outc[no] - outc[no-1] != 12) begin errors++; $display("FAIL b2b_period blk=%0d: got %0d want 12", no, outc[no] - outc[no-1]); end
        end
        no++;
      end
      if (in_ready_w[0] === 1'b1 && na < 4) begin
        in_valid_a[0] = 1'b1; in_data_a[0] = blk[na]; acc[na] = cyc; na++;
      end else if (in_ready_w[0] === 1'b1) begin
        in_valid_a[0] = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    in_valid_a[0] = 1'b0;
    out_ready_a[0] = 1'b0;
    checks++; if (no != 4) begin errors++; $display("FAIL b2b_count: got %0d blocks want 4", no); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_data_a[d] = '0;
      for (int r = 0; r < 16; r++) rks[d][r] = '0;
    end
    init_sbox();
    test_reset();
    test_fips_b();
    test_fips_c();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES encryption datapath that wraps the existing 16-way S-box stage. Each clock it applies one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) to a 128-bit state register. It sits between the block-input interface and the ciphertext output. Round keys are fetched from an external expanded-key store through an index port, so one engine serves AES-128, AES-192 and AES-256 through a single parameter.

## Interface
- NR, 10, number of rounds: 10 (AES-128), 12 (AES-192) or 14 (AES-256); other values unsupported.

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  plaintext block offered
- in_ready  out  1  engine can accept a block (high only in IDLE)
- in_data  in  128  plaintext; byte 0 = [127:120], FIPS-197 column-major (byte 4c+r = state[r][c])
- rk_idx  out  4  index of round key required this cycle
- rk  in  128  round key for rk_idx, valid combinationally in the same cycle; same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext (state register)
- busy  out  1  high in ROUND or DONE

## Operation
- FSM states: IDLE, ROUND, DONE. Registers: st[127:0], round[3:0].
- IDLE: in_ready=1, rk_idx=0. On in_valid&&in_ready: st <= in_data ^ rk, round <= 1, go ROUND. Otherwise hold.
- ROUND: rk_idx=round.
  - round<NR: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk, round <= round+1.
  - round==NR: st <= ShiftRows(SubBytes(st)) ^ rk (no MixColumns), go DONE.
- DONE: out_valid=1, out_data=st, rk_idx=0. On out_ready: go IDLE, round <= 0. st holds until the next accept.
- SubBytes: the existing 16-instance S-box stage, combinational on st.
- ShiftRows: row r rotated left by r bytes.
- MixColumns: standard GF(2^8) matrix [2 3 1 1] circulant, xtime with reduction polynomial 0x1B; all arithmetic 8-bit XOR, no carries.
- in_valid while busy is ignored; no buffering, the block is not captured.
- out_data is meaningful only while out_valid=1.

## Timing
- Reset values: FSM=IDLE, st=0, round=0, so in_ready=1, out_valid=0, busy=0, rk_idx=0, out_data=0.
- Accept edge T. ROUND spans cycles T+1..T+NR. out_valid first high in cycle T+NR+1, i.e. NR cycles after the accept edge.
- Minimum block period is NR+2 cycles: accept, NR rounds, one DONE cycle with out_ready=1. The next accept is possible in the cycle after the DONE handshake.
- Backpressure: out_valid and out_data stay stable for any number of cycles with out_ready=0.
- out_ready while not in DONE has no effect.
- rk must settle within the same cycle as rk_idx; the engine registers only st, round and FSM.
- Reset asserted mid-operation aborts the block at once with no output, and all outputs return to reset values asynchronously. The first accept is allowed on the first edge after deassertion.
- round never exceeds NR, and 4 bits covers NR=14.

## Test plan
- NR=10, FIPS-197 B: in 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, model-supplied rk -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- NR=10/12/14, FIPS-197 C.1/C.2/C.3: in 00112233445566778899aabbccddeeff, key 000102..0f/..17/..1f -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089; rk_idx sequence must be 0,1..NR.
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> out_data stable, in_ready=0 throughout; release -> in_ready=1 next cycle.
- Busy ignore: pulse in_valid with ffff...ff during ROUND -> result equals the original vector, and no extra out_valid occurs.
- Reset mid-op: assert reset at round 5 -> out_valid=0, in_ready=1, busy=0 immediately; a fresh vector then completes correctly.
- Back-to-back: 4 random blocks with in_valid and out_ready held high -> all match the model, with one block per NR+2 cycles.
